// File: rtl/box_pkg.sv
// Shared types and saturating coordinate helpers for the bounding-box extractor.
package box_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int COORD_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   valid;
        coord_t l;
        coord_t r;
        coord_t t;
        coord_t b;
    } box_t;

    typedef struct packed {
        coord_t l;
        coord_t r;
        coord_t t;
        coord_t b;
    } rect_t;

    typedef struct packed {
        logic   en;
        logic   bin;
        logic   de;
        logic   vs;
        coord_t x;
        coord_t y;
    } stage_t;

    function automatic coord_t sat_add(coord_t a, coord_t d);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, d};
        return s[COORD_W] ? {COORD_W{1'b1}} : s[COORD_W-1:0];
    endfunction

    function automatic coord_t sat_sub(coord_t a, coord_t d);
        logic [COORD_W:0] s;
        s = {1'b0, a} - {1'b0, d};
        return s[COORD_W] ? '0 : s[COORD_W-1:0];
    endfunction

    // Width and height are inclusive spans; r >= l and b >= t always hold for a valid slot.
    function automatic logic box_fits(box_t bx, logic [COORD_W:0] min_size);
        logic [COORD_W:0] w;
        logic [COORD_W:0] h;
        w = {1'b0, bx.r} - {1'b0, bx.l} + 1'b1;
        h = {1'b0, bx.b} - {1'b0, bx.t} + 1'b1;
        return bx.valid && (w >= min_size) && (h >= min_size);
    endfunction

endpackage

// File: rtl/box_extractor_if.sv
// Mask pixel stream in, published box list out. The extractor takes the slave side.
interface box_extractor_if;
    import box_pkg::*;

    logic   en;
    logic   i_bin;
    logic   i_de;
    logic   i_vsync;
    coord_t hcount;
    coord_t vcount;

    coord_t hcount_l1, hcount_l2, hcount_l3, hcount_l4;
    coord_t hcount_r1, hcount_r2, hcount_r3, hcount_r4;
    coord_t vcount_l1, vcount_l2, vcount_l3, vcount_l4;
    coord_t vcount_r1, vcount_r2, vcount_r3, vcount_r4;
    logic [3:0] number;
    logic       o_overflow;
    logic       o_frame_done;

    modport slave (
        input  en, i_bin, i_de, i_vsync, hcount, vcount,
        output hcount_l1, hcount_l2, hcount_l3, hcount_l4,
        output hcount_r1, hcount_r2, hcount_r3, hcount_r4,
        output vcount_l1, vcount_l2, vcount_l3, vcount_l4,
        output vcount_r1, vcount_r2, vcount_r3, vcount_r4,
        output number, o_overflow, o_frame_done
    );

    modport master (
        output en, i_bin, i_de, i_vsync, hcount, vcount,
        input  hcount_l1, hcount_l2, hcount_l3, hcount_l4,
        input  hcount_r1, hcount_r2, hcount_r3, hcount_r4,
        input  vcount_l1, vcount_l2, vcount_l3, vcount_l4,
        input  vcount_r1, vcount_r2, vcount_r3, vcount_r4,
        input  number, o_overflow, o_frame_done
    );

endinterface

// File: rtl/box_slot.sv
// One working box: holds its extent, reports whether a pixel falls in its merge window,
// and grows, allocates or clears on command.
module box_slot
    import box_pkg::*;
#(
    parameter int MERGE_DIST = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  coord_t x,
    input  coord_t y,
    input  logic   alloc,
    input  logic   upd,
    input  logic   clr,
    output logic   match,
    output box_t   box
);

    localparam coord_t MD = coord_t'(MERGE_DIST);

    box_t box_q;
    box_t box_d;

    always_comb begin
        match = box_q.valid
             && (x >= sat_sub(box_q.l, MD)) && (x <= sat_add(box_q.r, MD))
             && (y >= sat_sub(box_q.t, MD)) && (y <= sat_add(box_q.b, MD));
    end

    always_comb begin
        box_d = box_q;
        if (clr) begin
            box_d = '0;
        end else if (alloc) begin
            box_d = '{valid: 1'b1, l: x, r: x, t: y, b: y};
        end else if (upd) begin
            if (x < box_q.l) box_d.l = x;
            if (x > box_q.r) box_d.r = x;
            if (y < box_q.t) box_d.t = y;
            if (y > box_q.b) box_d.b = y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) box_q <= '0;
        else     box_q <= box_d;
    end

    assign box = box_q;

endmodule

// File: rtl/box_extractor.sv
// Grows up to four boxes per frame from the binarised mask and publishes the
// size-filtered, compacted list at every vsync rising edge.
module box_extractor
    import box_pkg::*;
#(
    parameter int MERGE_DIST = 8,
    parameter int MIN_SIZE   = 4
) (
    input  logic pixelclk,
    input  logic reset,
    box_extractor_if.slave bus
);

    localparam logic [COORD_W:0] MIN_W = (COORD_W+1)'(MIN_SIZE);

    stage_t stg_q, stg_d;
    logic   vs_prev_q, vs_prev_d;
    logic   flag_q, flag_d;

    rect_t      out_q [NUM_SLOTS];
    rect_t      out_d [NUM_SLOTS];
    logic [3:0] number_q, number_d;
    logic       ovf_q, ovf_d;
    logic       done_q, done_d;

    logic                 frame_end;
    logic                 ev;
    logic                 ovf_ev;
    logic                 found;
    logic [2:0]           n;
    logic [NUM_SLOTS-1:0] match, alloc, upd;
    box_t                 slot_box [NUM_SLOTS];

    always_comb begin
        stg_d     = '{en: bus.en, bin: bus.i_bin, de: bus.i_de, vs: bus.i_vsync,
                      x: bus.hcount, y: bus.vcount};
        vs_prev_d = stg_q.vs;
    end

    // A pixel landing on the frame-end cycle belongs to neither frame and is dropped.
    assign frame_end = stg_q.vs & ~vs_prev_q;
    assign ev        = stg_q.de & stg_q.bin & stg_q.en & ~frame_end;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        box_slot #(.MERGE_DIST(MERGE_DIST)) u_slot (
            .clk   (pixelclk),
            .rst   (reset),
            .x     (stg_q.x),
            .y     (stg_q.y),
            .alloc (alloc[s]),
            .upd   (upd[s]),
            .clr   (frame_end),
            .match (match[s]),
            .box   (slot_box[s])
        );
    end

    // Lowest matching slot grows; otherwise lowest free slot allocates; otherwise overflow.
    always_comb begin
        alloc  = '0;
        upd    = '0;
        ovf_ev = 1'b0;
        found  = 1'b0;
        if (ev) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!found && match[i]) begin
                    upd[i] = 1'b1;
                    found  = 1'b1;
                end
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!found && !slot_box[i].valid) begin
                    alloc[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            ovf_ev = !found;
        end
    end

    always_comb begin
        flag_d = frame_end ? 1'b0 : (flag_q | ovf_ev);
    end

    always_comb begin
        out_d    = out_q;
        number_d = number_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        n        = '0;
        if (frame_end) begin
            for (int i = 0; i < NUM_SLOTS; i++) out_d[i] = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (box_fits(slot_box[i], MIN_W)) begin
                    out_d[n[1:0]] = '{l: slot_box[i].l, r: slot_box[i].r,
                                      t: slot_box[i].t, b: slot_box[i].b};
                    n = n + 3'd1;
                end
            end
            number_d = {1'b0, n};
            ovf_d    = flag_q;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            stg_q     <= '0;
            vs_prev_q <= 1'b0;
            flag_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) out_q[i] <= '0;
            number_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            vs_prev_q <= vs_prev_d;
            flag_q    <= flag_d;
            for (int i = 0; i < NUM_SLOTS; i++) out_q[i] <= out_d[i];
            number_q  <= number_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.hcount_l1 = out_q[0].l;
    assign bus.hcount_r1 = out_q[0].r;
    assign bus.vcount_l1 = out_q[0].t;
    assign bus.vcount_r1 = out_q[0].b;
    assign bus.hcount_l2 = out_q[1].l;
    assign bus.hcount_r2 = out_q[1].r;
    assign bus.vcount_l2 = out_q[1].t;
    assign bus.vcount_r2 = out_q[1].b;
    assign bus.hcount_l3 = out_q[2].l;
    assign bus.hcount_r3 = out_q[2].r;
    assign bus.vcount_l3 = out_q[2].t;
    assign bus.vcount_r3 = out_q[2].b;
    assign bus.hcount_l4 = out_q[3].l;
    assign bus.hcount_r4 = out_q[3].r;
    assign bus.vcount_l4 = out_q[3].t;
    assign bus.vcount_r4 = out_q[3].b;

    assign bus.number       = number_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_frame_done = done_q;

endmodule

// File: doc/box_extractor.md
# box_extractor

Producer of the bounding-box coordinate set consumed by the on-screen box overlay. Scans the binarised fruit mask stream pixel by pixel, grows up to four axis-aligned boxes per frame from mask pixels, and at each frame end publishes the compacted box list and object count. Sits between the colour-threshold/binarisation stage and the display overlay, in the pixel clock domain.

## Interface
- MERGE_DIST, 8, pixel distance within which a mask pixel joins an existing box (each axis)
- MIN_SIZE, 4, minimum box width and height (r-l+1, b-t+1) for a box to be published
- pixelclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset; one clock, no other clock domains
- en  in  1  1 = accept mask pixels; 0 = ignore pixels, frame publishing continues
- i_bin  in  1  binarised mask pixel, 1 = fruit
- i_de  in  1  active-video qualifier
- i_vsync  in  1  vertical sync, active-high; rising edge = frame end
- hcount, vcount  in  12 each  coordinates of the current pixel
- hcount_l1..hcount_l4, hcount_r1..hcount_r4  out  12 each  box left/right columns
- vcount_l1..vcount_l4, vcount_r1..vcount_r4  out  12 each  box top/bottom rows
- number  out  4  published box count, 0-4
- o_overflow  out  1  last frame had a mask pixel that matched no box with no free slot
- o_frame_done  out  1  one-cycle pulse when outputs update

## Operation
- Input stage: i_bin, i_de, i_vsync, en, hcount, vcount registered once (stage 1); all logic uses stage-1 values.
- Working set: 4 slots, each {valid, l, r, t, b}. Pixel event = de & bin & en at stage 1.
- Match: slot s matches (x,y) if valid and l-MERGE_DIST <= x <= r+MERGE_DIST and t-MERGE_DIST <= y <= b+MERGE_DIST; subtraction saturates at 0, addition at 4095 (13-bit intermediate). Lowest-index matching slot wins and updates l=min(l,x), r=max(r,x), t=min(t,y), b=max(b,y) on the next edge. Other matching slots untouched (no slot merging).
- No match, free slot exists: lowest-index free slot set valid, l=r=x, t=b=y.
- No match, no free slot: pixel dropped, frame overflow flag set.
- Frame end (stage-1 vsync rising edge): slots with width and height >= MIN_SIZE are published in ascending slot order into outputs 1..N; outputs N+1..4 driven 0; number=N; o_overflow=frame flag; o_frame_done pulses. Same edge clears all slots and the flag. A pixel event coincident with the frame-end edge is dropped.
- Outputs hold unchanged between frame ends. Zeroed slots (l=r=t=b=0) draw nothing in the overlay.
- en low: no pixel events; frame end still publishes (typically number=0).

## Timing
- Reset: all outputs 0, number=0, o_overflow=0, o_frame_done=0, slots invalid, flag clear. Reset mid-frame discards partial boxes; next frame end publishes only pixels seen after reset release.
- Pixel latency: pixel at pins cycle k updates its slot at edge k+2; back-to-back pixels every cycle supported (slot compare uses current registers, no hazard).
- Frame-end latency: i_vsync first high at pins cycle E -> outputs, number, o_overflow valid and o_frame_done high during cycle E+2; o_frame_done low at E+3.
- Last active pixel before vsync is always included (same pipeline depth).

## Structure
- Package box_pkg: NUM_SLOTS=4, COORD_W=12, box_t struct {valid, l, r, t, b}, saturating +/- helper functions.
- Sub-module box_slot: one slot's registers, match compare, min/max update, allocate and clear inputs; instantiated 4 times. Top holds input stage, priority select, overflow flag, MIN_SIZE filter, compaction, output registers.

## Test plan
- Reset then single frame with mask pixels filling rectangle x=100..139, y=50..89 -> after frame end: hcount_l1=100, hcount_r1=139, vcount_l1=50, vcount_r1=89, number=1, others 0, o_frame_done one cycle at E+2.
- Two rectangles x=10..29/y=10..29 and x=200..219/y=300..319 -> number=2, slot order by first pixel in raster order; gap of 9 pixels (> MERGE_DIST=8) yields two boxes, gap of 8 merges to one.
- Five separated blobs -> number=4, fifth blob absent, o_overflow=1; next clean frame -> o_overflow=0.
- Isolated 3x3 blob plus 20x20 blob in slot 2 -> 3x3 filtered, 20x20 published as box 1, number=1.
- en=0 for whole frame with mask active -> number=0, all coordinates 0; pixel at x=0,y=0 with en=1 -> saturating compare, box 0..0 filtered by MIN_SIZE.
- Assert reset mid-frame after first blob, release before second -> only second blob published.
